// File: rtl/proc_control_unit.sv
// Multi-cycle control unit: latches one instruction, executes it on a six-entry register file,
// then pulses done (PC += 1) or branch (PC load). Optional SUB opcode is enabled by CTRL_SUB_EN.
module proc_control_unit #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [9:0]        instruction,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [2:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              branch,
  output logic [5:0]        branchaddress,
  output logic              busy
);

  localparam int unsigned OP_SIZE  = 4;
  localparam int unsigned ARG_SIZE = 3;
  localparam int unsigned ARG_NUM  = 2;
  localparam int unsigned INSTR_W  = OP_SIZE + ARG_SIZE * ARG_NUM;
  localparam int unsigned NREGS    = 6;

  localparam logic [OP_SIZE-1:0] OP_LOAD = 4'b0000;
  localparam logic [OP_SIZE-1:0] OP_MOVE = 4'b0001;
  localparam logic [OP_SIZE-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_SIZE-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_SIZE-1:0] OP_BR   = 4'b1000;
`ifdef CTRL_SUB_EN
  localparam logic [OP_SIZE-1:0] OP_SUB  = 4'b0100;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_LDWAIT = 3'd2,
    S_EX1    = 3'd3,
    S_EX2    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [INSTR_W-1:0]        ir_q, ir_d;
  logic [DATA_W-1:0]         a_q, a_d;
  logic [DATA_W-1:0]         g_q, g_d;
  logic [DATA_W-1:0]         regs_q [NREGS];
  logic [DATA_W-1:0]         regs_d [NREGS];
  logic                      done_q, done_d;
  logic                      branch_q, branch_d;
  logic                      busy_q, busy_d;
  logic [2*ARG_SIZE-1:0]     br_addr_q, br_addr_d;

  logic [OP_SIZE-1:0]        op;
  logic [ARG_SIZE-1:0]       rx, ry;
  logic [DATA_W-1:0]         rf_view [8];
  logic [DATA_W-1:0]         rx_val, ry_val;
  logic                      is_alu;
  logic                      wr_en;
  logic [DATA_W-1:0]         wr_data;

  assign op = ir_q[INSTR_W-1 -: OP_SIZE];
  assign rx = ir_q[2*ARG_SIZE-1 -: ARG_SIZE];
  assign ry = ir_q[ARG_SIZE-1:0];

  // Address 0 (NA) and 7 (PC) always read as zero
  always_comb begin
    rf_view = '{'0, regs_q[0], regs_q[1], regs_q[2], regs_q[3], regs_q[4], regs_q[5], '0};
  end

  assign rx_val  = rf_view[rx];
  assign ry_val  = rf_view[ry];
  assign rd_data = rf_view[rd_sel];

`ifdef CTRL_SUB_EN
  assign is_alu = (op == OP_ADD) || (op == OP_XOR) || (op == OP_SUB);
`else
  assign is_alu = (op == OP_ADD) || (op == OP_XOR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (run) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LOAD) state_d = S_LDWAIT;
        else if (is_alu)   state_d = S_EX1;
        else               state_d = S_FETCH;
      end
      S_LDWAIT: if (din_valid) state_d = S_FETCH;
      S_EX1:    state_d = S_EX2;
`ifdef CTRL_SUB_EN
      S_EX2:    state_d = (op == OP_SUB) ? S_WB : S_FETCH;
`else
      S_EX2:    state_d = S_FETCH;
`endif
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath updates and next values of the registered pulses
  always_comb begin
    ir_d      = ir_q;
    a_d       = a_q;
    g_d       = g_q;
    done_d    = 1'b0;
    branch_d  = 1'b0;
    br_addr_d = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state_q)
      S_FETCH: if (run) ir_d = instruction;
      S_DECODE: begin
        if (op == OP_LOAD) begin
          done_d = 1'b0;
        end else if (op == OP_MOVE) begin
          wr_en   = 1'b1;
          wr_data = ry_val;
          done_d  = 1'b1;
        end else if (is_alu) begin
          a_d = rx_val;
        end else if (op == OP_BR) begin
          branch_d  = 1'b1;
          br_addr_d = {rx, ry};
        end else begin
          done_d = 1'b1;
        end
      end
      S_LDWAIT: begin
        if (din_valid) begin
          wr_en   = 1'b1;
          wr_data = din;
          done_d  = 1'b1;
        end
      end
      S_EX1: begin
        if (op == OP_ADD)      g_d = a_q + ry_val;
        else if (op == OP_XOR) g_d = a_q ^ ry_val;
`ifdef CTRL_SUB_EN
        else if (op == OP_SUB) g_d = a_q - ry_val;
`endif
      end
      S_EX2: begin
`ifdef CTRL_SUB_EN
        if (op != OP_SUB) begin
          wr_en   = 1'b1;
          wr_data = g_q;
          done_d  = 1'b1;
        end
`else
        wr_en   = 1'b1;
        wr_data = g_q;
        done_d  = 1'b1;
`endif
      end
      S_WB: begin
        wr_en   = 1'b1;
        wr_data = g_q;
        done_d  = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != S_FETCH);

    regs_d = regs_q;
    if (wr_en && (rx != 3'd0) && (rx != 3'd7)) regs_d[rx - 3'd1] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      a_q       <= '0;
      g_q       <= '0;
      regs_q    <= '{default: '0};
      done_q    <= 1'b0;
      branch_q  <= 1'b0;
      busy_q    <= 1'b0;
      br_addr_q <= '0;
    end else begin
      ir_q      <= ir_d;
      a_q       <= a_d;
      g_q       <= g_d;
      regs_q    <= regs_d;
      done_q    <= done_d;
      branch_q  <= branch_d;
      busy_q    <= busy_d;
      br_addr_q <= br_addr_d;
    end
  end

  assign done          = done_q;
  assign branch        = branch_q;
  assign busy          = busy_q;
  assign branchaddress = br_addr_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: directed cases plus random instructions against a register-level model.
module tb_proc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [9:0] instruction;
  logic [7:0] din;
  logic       din_valid;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic       done;
  logic       branch;
  logic [5:0] branchaddress;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_br    = 0;
  logic [7:0] m_r [8];

  proc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction),
    .din(din), .din_valid(din_valid), .rd_sel(rd_sel), .rd_data(rd_data),
    .done(done), .branch(branch), .branchaddress(branchaddress), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [2:0] s;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      rd_sel = s;
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(m_r[s]));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
  endtask

  // One instruction from FETCH to its retire pulse; latency and results come from the opcode rules
  task automatic exec(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                      input logic [7:0] dval, input int wait_n);
    int exp_lat;
    bit is_br;
    bit seen;
    int k;
    is_br = (op == 4'b1000);
    case (op)
      4'b0000: exp_lat = 3 + wait_n;
      4'b0010, 4'b0011: exp_lat = 4;
`ifdef CTRL_SUB_EN
      4'b0100: exp_lat = 5;
`endif
      default: exp_lat = 2;
    endcase
    @(negedge clk);
    instruction = {op, rx, ry};
    run         = 1'b1;
    din_valid   = 1'b0;
    din         = dval;
    @(negedge clk);
    run         = 1'b0;
    instruction = 10'($urandom);
    k    = 1;
    seen = 1'b0;
    check("busy_decode", 32'(busy), 32'd1);
    while (k < 40 && !seen) begin
      if (done || branch) begin
        seen = 1'b1;
      end else begin
        din_valid = (k >= 2 + wait_n);
        @(negedge clk);
        k++;
      end
    end
    din_valid = 1'b0;
    if (!seen) begin
      check("retire_timeout", 32'd0, 32'd1);
      return;
    end
    if (done) n_done++;
    if (branch) n_br++;
    check("latency", 32'(k), 32'(exp_lat));
    check("done", 32'(done), 32'(!is_br));
    check("branch", 32'(branch), 32'(is_br));
    if (is_br) check("braddr", 32'(branchaddress), 32'({rx, ry}));
    check("busy_retired", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_1cyc", 32'(done), 32'd0);
    check("branch_1cyc", 32'(branch), 32'd0);
    case (op)
      4'b0000: m_r[rx] = dval;
      4'b0001: m_r[rx] = m_r[ry];
      4'b0010: m_r[rx] = m_r[rx] + m_r[ry];
      4'b0011: m_r[rx] = m_r[rx] ^ m_r[ry];
`ifdef CTRL_SUB_EN
      4'b0100: m_r[rx] = m_r[rx] - m_r[ry];
`endif
      default: ;
    endcase
    m_r[0] = 8'h00;
    m_r[7] = 8'h00;
    check_regs("rf");
  endtask

  initial begin
    int d0;
    int b0;
    logic [3:0] op;
    rst_n       = 1'b0;
    run         = 1'b0;
    instruction = '0;
    din         = '0;
    din_valid   = 1'b0;
    rd_sel      = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_branch", 32'(branch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_braddr", 32'(branchaddress), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check_regs("rst");

    // LOAD with din_valid held off for three cycles
    exec(4'b0000, 3'd1, 3'd0, 8'h05, 3);
    rd_sel = 3'd1; #1;
    check("load_r1", 32'(rd_data), 32'h05);

    // Short program: seven retirements, no branches
    d0 = n_done; b0 = n_br;
    exec(4'b0000, 3'd1, 3'd0, 8'h05, 0);
    exec(4'b0001, 3'd2, 3'd3, 8'h00, 0);
    exec(4'b0010, 3'd1, 3'd2, 8'h00, 0);
    exec(4'b0010, 3'd3, 3'd2, 8'h00, 0);
    exec(4'b0011, 3'd2, 3'd1, 8'h00, 0);
    exec(4'b0011, 3'd3, 3'd2, 8'h00, 0);
    exec(4'b0010, 3'd2, 3'd3, 8'h00, 0);
    check("prog_dones", 32'(n_done - d0), 32'd7);
    check("prog_branches", 32'(n_br - b0), 32'd0);
    rd_sel = 3'd1; #1;
    check("prog_r1", 32'(rd_data), 32'h05);
    rd_sel = 3'd3; #1;
    check("prog_r3", 32'(rd_data), 32'h05);

    // ADD wrap-around
    exec(4'b0000, 3'd1, 3'd0, 8'hF0, 1);
    exec(4'b0000, 3'd2, 3'd0, 8'h20, 0);
    exec(4'b0010, 3'd1, 3'd2, 8'h00, 0);
    rd_sel = 3'd1; #1;
    check("add_wrap", 32'(rd_data), 32'h10);

    // Branch then stall with run low
    exec(4'b1000, 3'd0, 3'd2, 8'h00, 0);
    repeat (3) begin
      @(negedge clk);
      check("stall_busy", 32'(busy), 32'd0);
      check("stall_done", 32'(done), 32'd0);
    end

    // Opcode 0100: SUB when enabled, NOP otherwise
    exec(4'b0000, 3'd1, 3'd0, 8'h03, 0);
    exec(4'b0000, 3'd2, 3'd0, 8'h05, 0);
    exec(4'b0100, 3'd1, 3'd2, 8'h00, 0);
    rd_sel = 3'd1; #1;
`ifdef CTRL_SUB_EN
    check("op0100", 32'(rd_data), 32'hFE);
`else
    check("op0100", 32'(rd_data), 32'h03);
`endif

    // Doubling with rx = ry
    exec(4'b0010, 3'd2, 3'd2, 8'h00, 0);

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       op = 4'b0000;
        1:       op = 4'b0001;
        2:       op = 4'b0010;
        3:       op = 4'b0011;
        4:       op = 4'b1000;
        5:       op = 4'b0100;
        default: op = 4'($urandom);
      endcase
      exec(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           8'($urandom), int'($urandom_range(0, 4)));
    end

    // Reset asserted while an ADD sits in EX1
    exec(4'b0000, 3'd1, 3'd0, 8'h7A, 0);
    @(negedge clk);
    instruction = {4'b0010, 3'd1, 3'd1};
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_branch", 32'(branch), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    model_clear();
    check_regs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_done", 32'(done), 32'd0);
    check_regs("postrst");
    exec(4'b0000, 3'd6, 3'd0, 8'hC3, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
